// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: PC FunSel codes and FSM states.
package fetch_sequencer_pkg;

  // FunSel codes understood by the PC counter register
  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_FETCH_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: clears/loads/increments the PC, reads two
// little-endian bytes from memory and hands the assembled word to decode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int IR_W   = 2 * BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              branch_req,
  input  logic [BYTE_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              mem_req,
  output logic [1:0]        pc_funsel,
  output logic              pc_enable,
  output logic [IR_W-1:0]   ir_out,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              busy
);

  state_t          state_reg;
  logic [IR_W-1:0] ir_reg;
  logic            ir_valid_reg;

  // PC and memory controls decode straight from the state so the PC moves on
  // the same edge a byte is captured; all held quiet while reset is asserted.
  always_comb begin
    mem_req   = 1'b0;
    pc_enable = 1'b0;
    pc_funsel = FS_CLEAR;
    if (rst_n) begin
      case (state_reg)
        ST_INIT: begin
          pc_enable = 1'b1;
        end
        ST_IDLE: begin
          if (branch_req) begin
            pc_enable = 1'b1;
            pc_funsel = FS_LOAD;
          end
        end
        ST_FETCH_LO, ST_FETCH_HI: begin
          mem_req = 1'b1;
          if (mem_valid) begin
            pc_enable = 1'b1;
            pc_funsel = FS_INC;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, byte capture into the instruction register and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: state_reg <= ST_IDLE;
        ST_IDLE: begin
          // a branch this cycle wins; start must still be high next cycle
          if (!branch_req && start) state_reg <= ST_FETCH_LO;
        end
        ST_FETCH_LO: begin
          if (mem_valid) begin
            ir_reg[BYTE_W-1:0] <= mem_data;
            state_reg          <= ST_FETCH_HI;
          end
        end
        ST_FETCH_HI: begin
          if (mem_valid) begin
            ir_reg[IR_W-1:BYTE_W] <= mem_data;
            ir_valid_reg          <= 1'b1;
            state_reg             <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ir_ack) begin
            ir_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign ir_out   = ir_reg;
  assign ir_valid = ir_valid_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch control stage that sits directly upstream of the n-bit FunSel counter register used as the program counter (PC).
- Drives the PC register's FunSel/enable pins.
- Requests bytes from memory and assembles two little-endian bytes into one instruction word.
- Presents the instruction to decode with a valid/ack handshake.
- Also clears the PC after reset, because the PC register has no reset of its own.

Parameters:
BYTE_W, 8, memory data width in bits.
IR_W, 16, instruction width in bits; fixed at 2*BYTE_W.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  level request to fetch the next instruction.
branch_req  input  1  load the PC from the external target mux (PC FunSel=01).
mem_data  input  BYTE_W  byte returned by memory.
mem_valid  input  1  mem_data is valid this cycle.
mem_req  output  1  memory read request.
pc_funsel  output  2  FunSel to the PC register.
pc_enable  output  1  enable to the PC register.
ir_out  output  IR_W  assembled instruction.
ir_valid  output  1  ir_out is complete and stable.
ir_ack  input  1  decode has consumed ir_out.
busy  output  1  high in any state except IDLE.

Behaviour:
- Interface decision: one clock (clk); asynchronous, active-low reset (rst_n).
- Reset (rst_n=0, async):
  - State is INIT; ir_out=0; ir_valid=0.
  - mem_req=0, pc_enable=0, pc_funsel=00.
- Output timing:
  - pc_funsel, pc_enable and mem_req are combinational from state and inputs, so the PC updates on the same edge a byte is captured.
  - ir_out and ir_valid are registered.
- State INIT (exactly one cycle after reset release):
  - Drive pc_enable=1, pc_funsel=00 (clear PC); busy=1.
  - Next state: IDLE.
- State IDLE:
  - busy=0.
  - If branch_req: pc_enable=1, pc_funsel=01 for this cycle; stay in IDLE.
  - Else if start: go to FETCH_LO.
  - branch_req has priority over start in the same cycle; start must be held to be seen next cycle.
  - Otherwise pc_enable=0.
- State FETCH_LO:
  - mem_req=1.
  - On mem_valid: ir_out[BYTE_W-1:0] <= mem_data; pc_enable=1, pc_funsel=11 (increment); go to FETCH_HI.
  - Without mem_valid: wait indefinitely, pc_enable=0.
- State FETCH_HI:
  - mem_req=1.
  - On mem_valid: ir_out[IR_W-1:BYTE_W] <= mem_data; PC increment as above; go to DONE.
  - ir_valid is set on the same edge.
- State DONE:
  - ir_valid=1, mem_req=0, pc_enable=0.
  - If ir_ack: clear ir_valid; go to IDLE.
  - ir_out is stable for the whole time ir_valid=1.
- Exactly two PC increments per completed fetch. The PC never receives FunSel=10 (decrement) from this block.
- branch_req and start outside IDLE are ignored; the requester must hold them.
- mem_valid outside FETCH_LO/FETCH_HI is ignored.
- Reset mid-fetch:
  - Immediate return to INIT; the partial ir_out is cleared.
  - The PC is re-cleared in the next cycle.
- pc_funsel value when pc_enable=0: don't-care, but driven to 00.

Decomposition:
- Shared package holds:
  - FunSel constants: FS_CLEAR=2'b00, FS_LOAD=2'b01, FS_DEC=2'b10, FS_INC=2'b11.
  - State encoding: INIT, IDLE, FETCH_LO, FETCH_HI, DONE (3-bit).
- Single module; no sub-module. The FSM and byte-capture register are small enough to stay together.
- The bench instantiates the existing counter register as the PC, with n=8, to check the end-to-end PC value.

Test Plan:
- Reset release -> one cycle with pc_enable=1, pc_funsel=00; PC register reads 0x00; then busy=0.
- start=1; mem_valid on consecutive cycles with 0x34 then 0x12 -> ir_out=0x1234 and ir_valid=1 in DONE; PC=0x02; two pc_funsel=11 pulses.
- Two wait cycles before each mem_valid -> mem_req held high throughout; no PC change while waiting; same final ir_out=0x1234, PC=0x02.
- branch_req=1 and start=1 together in IDLE, target mux=0x40 -> PC=0x40; fetch begins the following cycle; after 0xCD, 0xAB the result is ir_out=0xABCD, PC=0x42.
- ir_ack held low for 5 cycles in DONE -> ir_valid stays high and ir_out stays constant; start pulses are ignored; ack returns to IDLE.
- rst_n asserted after the low byte is captured -> ir_out=0 and ir_valid=0 immediately; INIT clears the PC; no stray increment.
